// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier.
// Used by the sequencing FSM, the datapath and the multiplier top level.
package booth_pkg;

    localparam int BOOTH_WIDTH = 16;
    localparam int BOOTH_CNT_W = 5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_M = 3'd1,
        S_LOAD_Q = 3'd2,
        S_CHECK  = 3'd3,
        S_ADD    = 3'd4,
        S_SUB    = 3'd5,
        S_SHIFT  = 3'd6,
        S_DONE   = 3'd7
    } booth_state_e;

    typedef struct packed {
        logic opnd_sel;
        logic ld_m;
        logic ld_q;
        logic ld_a;
        logic clr_a;
        logic clr_q;
        logic clr_ff;
        logic sft_a;
        logic sft_q;
        logic addsub;
        logic ld_cnt;
        logic decr;
        logic busy;
        logic done;
    } booth_ctrl_t;

    function automatic booth_ctrl_t booth_decode(booth_state_e s);
        booth_ctrl_t c;
        c      = '0;
        c.busy = (s != S_IDLE);
        unique case (s)
            S_IDLE: ;
            S_LOAD_M: begin
                c.ld_m  = 1'b1;
                c.clr_a = 1'b1;
            end
            S_LOAD_Q: begin
                c.opnd_sel = 1'b1;
                c.ld_q     = 1'b1;
                c.clr_ff   = 1'b1;
                c.ld_cnt   = 1'b1;
            end
            S_CHECK: ;
            S_ADD: begin
                c.ld_a   = 1'b1;
                c.addsub = 1'b1;
            end
            S_SUB: begin
                c.ld_a = 1'b1;
            end
            S_SHIFT: begin
                c.sft_a = 1'b1;
                c.sft_q = 1'b1;
                c.decr  = 1'b1;
            end
            S_DONE: begin
                c.done = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/booth_datapath.sv
// Booth multiplier datapath: A/Q/M registers, Q-1 flop, add/sub ALU, iteration counter.
// A carries one guard bit so a -2^(W-1) multiplicand cannot overflow the ALU.
module booth_datapath
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH,
    parameter int CNT_W = BOOTH_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               LdM,
    input  logic               LdQ,
    input  logic               LdA,
    input  logic               clrA,
    input  logic               clrQ,
    input  logic               clrff,
    input  logic               sftA,
    input  logic               sftQ,
    input  logic               addsub,
    input  logic               ldcnt,
    input  logic               decr,
    output logic               q0,
    output logic               qm1,
    output logic               eqz,
    output logic [2*WIDTH-1:0] prod
);

    logic [WIDTH:0]   a_q;
    logic [WIDTH:0]   a_d;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   alu;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] m_d;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             qm1_q;
    logic             qm1_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign m_ext = {m_q[WIDTH-1], m_q};
    assign alu   = addsub ? (a_q + m_ext) : (a_q - m_ext);

    always_comb begin
        m_d = m_q;
        if (LdM) begin
            m_d = data_in;
        end

        a_d = a_q;
        if (clrA) begin
            a_d = '0;
        end else if (LdA) begin
            a_d = alu;
        end else if (sftA) begin
            a_d = {a_q[WIDTH], a_q[WIDTH:1]};
        end

        q_d = q_q;
        if (clrQ) begin
            q_d = '0;
        end else if (LdQ) begin
            q_d = data_in;
        end else if (sftQ) begin
            q_d = {a_q[0], q_q[WIDTH-1:1]};
        end

        // Q-1 tracks Q[0] every cycle; only an explicit clear overrides it.
        qm1_d = clrff ? 1'b0 : q_q[0];

        cnt_d = cnt_q;
        if (ldcnt) begin
            cnt_d = CNT_W'(WIDTH);
        end else if (decr) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q   <= '0;
            m_q   <= '0;
            q_q   <= '0;
            qm1_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            m_q   <= m_d;
            q_q   <= q_d;
            qm1_q <= qm1_d;
            cnt_q <= cnt_d;
        end
    end

    assign q0   = q_q[0];
    assign qm1  = qm1_q;
    assign eqz  = (cnt_q == '0);
    assign prod = {a_q[WIDTH-1:0], q_q};

endmodule

// File: rtl/booth_controller.sv
// Moore sequencing FSM for the radix-2 Booth multiplier datapath.
// Every output is decoded from the state register alone.
module booth_controller
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH,
    parameter int CNT_W = BOOTH_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic q0,
    input  logic qm1,
    input  logic eqz,
    output logic opnd_sel,
    output logic LdM,
    output logic LdQ,
    output logic LdA,
    output logic clrA,
    output logic clrQ,
    output logic clrff,
    output logic sftA,
    output logic sftQ,
    output logic addsub,
    output logic ldcnt,
    output logic decr,
    output logic busy,
    output logic done
);

    if (WIDTH >= (1 << CNT_W)) begin : g_cnt_too_narrow
        $error("booth_controller: CNT_W cannot hold WIDTH");
    end

    booth_state_e state_q;
    booth_state_e state_d;
    booth_ctrl_t  ctrl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_M;
                end
            end
            S_LOAD_M: state_d = S_LOAD_Q;
            S_LOAD_Q: state_d = S_CHECK;
            S_CHECK: begin
                if (eqz) begin
                    state_d = S_DONE;
                end else begin
                    case ({q0, qm1})
                        2'b01:   state_d = S_ADD;
                        2'b10:   state_d = S_SUB;
                        default: state_d = S_SHIFT;
                    endcase
                end
            end
            S_ADD:   state_d = S_SHIFT;
            S_SUB:   state_d = S_SHIFT;
            S_SHIFT: state_d = S_CHECK;
            S_DONE:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl = booth_decode(state_q);
    end

    assign opnd_sel = ctrl.opnd_sel;
    assign LdM      = ctrl.ld_m;
    assign LdQ      = ctrl.ld_q;
    assign LdA      = ctrl.ld_a;
    assign clrA     = ctrl.clr_a;
    assign clrQ     = ctrl.clr_q;
    assign clrff    = ctrl.clr_ff;
    assign sftA     = ctrl.sft_a;
    assign sftQ     = ctrl.sft_q;
    assign addsub   = ctrl.addsub;
    assign ldcnt    = ctrl.ld_cnt;
    assign decr     = ctrl.decr;
    assign busy     = ctrl.busy;
    assign done     = ctrl.done;

endmodule
